// File: rtl/control_frame_commit_pkg.sv
// Shared packages for the frame-commit block.
//   params               : frame geometry defaults and derived TOTAL_BYTES
//   types                : address types used on the ports
//   control_frame_commit_pkg : local FSM state encoding
// Optional feature: DOUBLEBUFFER_EN adds the PENDING state (bank swap on the
// display frame boundary). Without it the block is single-buffered.
package params;
  localparam int PIXEL_WIDTH     = 4;
  localparam int PIXEL_HEIGHT    = 2;
  localparam int BYTES_PER_PIXEL = 2;
  localparam int TOTAL_BYTES     = PIXEL_WIDTH * PIXEL_HEIGHT * BYTES_PER_PIXEL;
endpackage

package types;
  // Upstream address fields carry one extra code point past the last legal
  // value so out-of-range requests are representable and can be rejected.
  typedef logic [$clog2(params::PIXEL_HEIGHT+1)-1:0]    row_addr_t;
  typedef logic [$clog2(params::PIXEL_WIDTH+1)-1:0]     col_addr_t;
  typedef logic [$clog2(params::BYTES_PER_PIXEL+1)-1:0] pixel_addr_t;
  // Linear byte offset plus the bank bit on top.
  typedef logic [$clog2(params::TOTAL_BYTES):0]         fb_addr_t;
endpackage

package control_frame_commit_pkg;
`ifdef DOUBLEBUFFER_EN
  typedef enum logic [1:0] {IDLE, FILL, PENDING} state_t;
`else
  typedef enum logic [1:0] {IDLE, FILL} state_t;
`endif
endpackage

// File: rtl/control_frame_commit_fb_linear_addr.sv
// fb_linear_addr: combinational pixel-to-linear-byte address.
//   row, column, pixel : upstream coordinates
//   bank               : bank being written (becomes the address MSB)
//   addr               : {bank, ((row*W)+column)*B+pixel}
// The product is formed at full fb_addr width. For legal coordinates the
// offset never reaches the MSB, so OR-ing the bank in is exact; illegal
// coordinates are never written, so their address value does not matter.
module fb_linear_addr #(
  parameter int PIXEL_WIDTH     = params::PIXEL_WIDTH,
  parameter int BYTES_PER_PIXEL = params::BYTES_PER_PIXEL
) (
  input  types::row_addr_t   row,
  input  types::col_addr_t   column,
  input  types::pixel_addr_t pixel,
  input  logic               bank,
  output types::fb_addr_t    addr
);
  localparam int AW = $bits(types::fb_addr_t);

  logic [AW-1:0] lin;

  assign lin  = ((AW'(row) * AW'(PIXEL_WIDTH)) + AW'(column)) * AW'(BYTES_PER_PIXEL)
              + AW'(pixel);
  assign addr = lin | {bank, {(AW-1){1'b0}}};
endmodule

// File: rtl/control_frame_commit.sv
// control_frame_commit: writes an upstream frame byte-by-byte into a frame
// buffer RAM and commits it to the display only when complete and clean.
//   clk, reset          : clock, synchronous active-high reset
//   row/column/pixel    : byte coordinates; data_in payload byte
//   ram_write_enable    : qualifies a byte; ram_access_start toggles per byte
//   done                : end of frame; display_frame_start: display boundary
//   fb_addr/fb_data/fb_we : registered RAM write port
//   display_bank        : bank the display scans out
//   frame_committed / frame_error : one-cycle status pulses
// Optional feature macro: DOUBLEBUFFER_EN (double buffering with a PENDING
// state that waits for display_frame_start before swapping banks).
module control_frame_commit
  import control_frame_commit_pkg::*;
#(
  parameter int PIXEL_WIDTH     = params::PIXEL_WIDTH,
  parameter int PIXEL_HEIGHT    = params::PIXEL_HEIGHT,
  parameter int BYTES_PER_PIXEL = params::BYTES_PER_PIXEL
) (
  input  logic               clk,
  input  logic               reset,
  input  types::row_addr_t   row,
  input  types::col_addr_t   column,
  input  types::pixel_addr_t pixel,
  input  logic [7:0]         data_in,
  input  logic               ram_write_enable,
  input  logic               ram_access_start,
  input  logic               done,
  input  logic               display_frame_start,
  output types::fb_addr_t    fb_addr,
  output logic [7:0]         fb_data,
  output logic               fb_we,
  output logic               display_bank,
  output logic               frame_committed,
  output logic               frame_error
);
  localparam int TOTAL = PIXEL_WIDTH * PIXEL_HEIGHT * BYTES_PER_PIXEL;
  localparam int CW    = $clog2(TOTAL) + 1;

  localparam types::row_addr_t   ROW_LIM = types::row_addr_t'(PIXEL_HEIGHT);
  localparam types::col_addr_t   COL_LIM = types::col_addr_t'(PIXEL_WIDTH);
  localparam types::pixel_addr_t PIX_LIM = types::pixel_addr_t'(BYTES_PER_PIXEL);

  state_t          state;
  logic            tog_q;
  logic [CW-1:0]   byte_count, cnt_n;
  logic            bad, bad_n;
  logic            byte_ev, can_take, frame_ok, write_bank;
  types::fb_addr_t lin_addr;

  assign byte_ev  = ram_write_enable && (ram_access_start != tog_q);
  assign can_take = (row < ROW_LIM) && (column < COL_LIM) && (pixel < PIX_LIM)
                 && (byte_count != CW'(TOTAL));

`ifdef DOUBLEBUFFER_EN
  logic disp_q;
  assign display_bank = disp_q;
  assign write_bank   = ~disp_q;
`else
  logic unused_dfs;
  assign unused_dfs   = display_frame_start;
  assign display_bank = 1'b0;
  assign write_bank   = 1'b0;
`endif

  fb_linear_addr #(
    .PIXEL_WIDTH    (PIXEL_WIDTH),
    .BYTES_PER_PIXEL(BYTES_PER_PIXEL)
  ) u_addr (
    .row   (row),
    .column(column),
    .pixel (pixel),
    .bank  (write_bank),
    .addr  (lin_addr)
  );

  // Count/bad including this cycle's byte, so a byte landing with done is
  // seen by the completeness check.
  always_comb begin
    cnt_n = byte_count;
    bad_n = bad;
    if (byte_ev) begin
      if (can_take) cnt_n = byte_count + CW'(1);
      else          bad_n = 1'b1;
    end
  end
  assign frame_ok = (cnt_n == CW'(TOTAL)) && !bad_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      tog_q           <= ram_access_start;
      byte_count      <= '0;
      bad             <= 1'b0;
      fb_we           <= 1'b0;
      fb_addr         <= '0;
      fb_data         <= '0;
      frame_committed <= 1'b0;
      frame_error     <= 1'b0;
`ifdef DOUBLEBUFFER_EN
      disp_q          <= 1'b0;
`endif
    end else begin
      tog_q           <= ram_access_start;
      fb_we           <= 1'b0;
      frame_committed <= 1'b0;
      frame_error     <= 1'b0;
      case (state)
        IDLE, FILL: begin
          if (byte_ev && can_take) begin
            fb_we   <= 1'b1;
            fb_addr <= lin_addr;
            fb_data <= data_in;
          end
          byte_count <= cnt_n;
          bad        <= bad_n;
          if (done) begin
            if (frame_ok) begin
`ifdef DOUBLEBUFFER_EN
              state <= PENDING;
`else
              frame_committed <= 1'b1;
              byte_count      <= '0;
              state           <= IDLE;
`endif
            end else begin
              // Short, overfull or corrupted frame (or done with no bytes).
              frame_error <= 1'b1;
              byte_count  <= '0;
              bad         <= 1'b0;
              state       <= IDLE;
            end
          end else if (byte_ev) begin
            state <= FILL;
          end
        end
`ifdef DOUBLEBUFFER_EN
        PENDING: begin
          // Frame is frozen until the display boundary; late bytes are lost.
          if (byte_ev) frame_error <= 1'b1;
          if (display_frame_start) begin
            disp_q          <= ~disp_q;
            frame_committed <= 1'b1;
            byte_count      <= '0;
            state           <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule
